// File: rtl/dcache_pkg.sv
// Shared geometry, array types, controller state encoding and address helpers
// for the direct-mapped data cache.
package dcache_pkg;

  localparam int NUM_IDX_BITS      = 6;
  localparam int BLOCK_OFFSET_BITS = 2;
  localparam int NUM_TAG_BITS      = 32 - NUM_IDX_BITS - BLOCK_OFFSET_BITS - 2;
  localparam int WORDS_PER_BLOCK   = 2 ** BLOCK_OFFSET_BITS;

  typedef logic [WORDS_PER_BLOCK-1:0][31:0] cache_data_block;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [NUM_TAG_BITS-1:0] tag;
  } cache_metadata_block;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL_WAIT,
    INSTALL,
    WB_REQ,
    RESP
  } dcache_state_e;

  function automatic logic [31:0] blk_addr(input logic [NUM_TAG_BITS-1:0] tag,
                                           input logic [NUM_IDX_BITS-1:0] idx);
    return {tag, idx, {(BLOCK_OFFSET_BITS + 2){1'b0}}};
  endfunction

  function automatic logic [BLOCK_OFFSET_BITS-1:0] word_sel(input logic [31:0] addr);
    return addr[BLOCK_OFFSET_BITS+1:2];
  endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Replaces one 32-bit word of a cache block; shared by the store-hit and
// store-miss install paths.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  cache_data_block              blk,
  input  logic [BLOCK_OFFSET_BITS-1:0] offset,
  input  logic [31:0]                  word,
  output cache_data_block              merged
);

  always_comb begin
    merged         = blk;
    merged[offset] = word;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped data cache sequencer: tag lookup, write-allocate refill,
// dirty-victim writeback, one request in flight.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  input  logic                req_we_i,
  input  logic [31:0]         req_addr_i,
  input  logic [31:0]         req_wdata_i,
  output logic                req_ready_o,
  output logic                resp_valid_o,
  output logic [31:0]         resp_rdata_o,
  output logic                arr_rd_en_o,
  output logic [31:0]         arr_rd_addr_o,
  input  cache_data_block     arr_rd_data_i,
  input  cache_metadata_block arr_rd_tag_i,
  output logic                arr_wr_en_o,
  output logic                arr_is_repair_o,
  output logic                arr_is_repair_dirty_o,
  output logic [31:0]         arr_wr_addr_o,
  output cache_data_block     arr_wr_data_o,
  input  logic                arr_wb_evicted_en_i,
  input  cache_data_block     arr_wb_evicted_block_i,
  output logic                mem_req_valid_o,
  output logic                mem_req_we_o,
  output logic [31:0]         mem_req_addr_o,
  output cache_data_block     mem_req_wdata_o,
  input  logic                mem_req_ready_i,
  input  logic                mem_resp_valid_i,
  input  cache_data_block     mem_resp_data_i
);

  dcache_state_e             state_q, state_d;
  logic [31:0]               addr_q;
  logic                      we_q;
  logic [31:0]               wdata_q;
  logic [NUM_TAG_BITS-1:0]   victim_tag_q;
  cache_data_block           victim_q;
  logic                      wb_pend_q;
  cache_data_block           refill_q;
  logic [31:0]               rdata_q;

  logic                      hit;
  cache_data_block           merge_base;
  cache_data_block           merged;
  logic [NUM_IDX_BITS-1:0]   idx_q;
  logic [NUM_TAG_BITS-1:0]   tag_q;

  assign tag_q = addr_q[31 -: NUM_TAG_BITS];
  assign idx_q = addr_q[BLOCK_OFFSET_BITS+2 +: NUM_IDX_BITS];
  assign hit   = arr_rd_tag_i.valid && (arr_rd_tag_i.tag == tag_q);

  dcache_word_merge u_merge (
    .blk    (merge_base),
    .offset (word_sel(addr_q)),
    .word   (wdata_q),
    .merged (merged)
  );

  // Outputs are forced low while rst_i is high so an abort drops any
  // in-flight memory request in the same cycle.
  always_comb begin
    state_d               = state_q;
    merge_base            = arr_rd_data_i;
    req_ready_o           = 1'b0;
    resp_valid_o          = 1'b0;
    resp_rdata_o          = '0;
    arr_rd_en_o           = 1'b0;
    arr_rd_addr_o         = '0;
    arr_wr_en_o           = 1'b0;
    arr_is_repair_o       = 1'b0;
    arr_is_repair_dirty_o = 1'b0;
    arr_wr_addr_o         = '0;
    arr_wr_data_o         = '0;
    mem_req_valid_o       = 1'b0;
    mem_req_we_o          = 1'b0;
    mem_req_addr_o        = '0;
    mem_req_wdata_o       = '0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          req_ready_o = 1'b1;
          if (req_valid_i) state_d = LOOKUP;
        end
        LOOKUP: begin
          arr_rd_en_o   = 1'b1;
          arr_rd_addr_o = addr_q;
          if (hit) begin
            if (we_q) begin
              arr_wr_en_o   = 1'b1;
              arr_wr_addr_o = addr_q;
              arr_wr_data_o = merged;
            end
            state_d = RESP;
          end else begin
            state_d = REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          mem_req_valid_o = 1'b1;
          mem_req_addr_o  = blk_addr(tag_q, idx_q);
          if (mem_req_ready_i) state_d = REFILL_WAIT;
        end
        REFILL_WAIT: begin
          if (mem_resp_valid_i) state_d = INSTALL;
        end
        INSTALL: begin
          merge_base            = refill_q;
          arr_wr_en_o           = 1'b1;
          arr_is_repair_o       = 1'b1;
          arr_is_repair_dirty_o = we_q;
          arr_wr_addr_o         = addr_q;
          arr_wr_data_o         = we_q ? merged : refill_q;
          state_d               = arr_wb_evicted_en_i ? WB_REQ : RESP;
        end
        WB_REQ: begin
          mem_req_valid_o = wb_pend_q;
          mem_req_we_o    = 1'b1;
          mem_req_addr_o  = blk_addr(victim_tag_q, idx_q);
          mem_req_wdata_o = victim_q;
          if (mem_req_ready_i || !wb_pend_q) state_d = RESP;
        end
        RESP: begin
          resp_valid_o = 1'b1;
          resp_rdata_o = rdata_q;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      victim_tag_q <= '0;
      victim_q     <= '0;
      wb_pend_q    <= 1'b0;
      refill_q     <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        addr_q  <= req_addr_i;
        we_q    <= req_we_i;
        wdata_q <= req_wdata_i;
      end
      if (state_q == LOOKUP) begin
        if (hit) rdata_q <= we_q ? 32'h0 : arr_rd_data_i[word_sel(addr_q)];
        else     victim_tag_q <= arr_rd_tag_i.tag;
      end
      if (state_q == REFILL_WAIT && mem_resp_valid_i) refill_q <= mem_resp_data_i;
      if (state_q == INSTALL) begin
        wb_pend_q <= arr_wb_evicted_en_i;
        victim_q  <= arr_wb_evicted_block_i;
        rdata_q   <= we_q ? 32'h0 : refill_q[word_sel(addr_q)];
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with a behavioural cache array and a
// block memory agent.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                req_valid_i, req_we_i;
  logic [31:0]         req_addr_i, req_wdata_i;
  logic                req_ready_o, resp_valid_o;
  logic [31:0]         resp_rdata_o;
  logic                arr_rd_en_o;
  logic [31:0]         arr_rd_addr_o;
  cache_data_block     arr_rd_data_i;
  cache_metadata_block arr_rd_tag_i;
  logic                arr_wr_en_o, arr_is_repair_o, arr_is_repair_dirty_o;
  logic [31:0]         arr_wr_addr_o;
  cache_data_block     arr_wr_data_o;
  logic                arr_wb_evicted_en_i;
  cache_data_block     arr_wb_evicted_block_i;
  logic                mem_req_valid_o, mem_req_we_o;
  logic [31:0]         mem_req_addr_o;
  cache_data_block     mem_req_wdata_o;
  logic                mem_req_ready_i, mem_resp_valid_i;
  cache_data_block     mem_resp_data_i;

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .arr_rd_en_o(arr_rd_en_o), .arr_rd_addr_o(arr_rd_addr_o),
    .arr_rd_data_i(arr_rd_data_i), .arr_rd_tag_i(arr_rd_tag_i),
    .arr_wr_en_o(arr_wr_en_o), .arr_is_repair_o(arr_is_repair_o),
    .arr_is_repair_dirty_o(arr_is_repair_dirty_o), .arr_wr_addr_o(arr_wr_addr_o),
    .arr_wr_data_o(arr_wr_data_o), .arr_wb_evicted_en_i(arr_wb_evicted_en_i),
    .arr_wb_evicted_block_i(arr_wb_evicted_block_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_we_o(mem_req_we_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i(mem_resp_data_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc = 0;
  int wr_cnt   = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural data_cache array: combinational read, posedge write.
  cache_data_block     arr_data [64];
  cache_metadata_block arr_meta [64];
  bit                  arr_init_done = 1'b0;

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[BLOCK_OFFSET_BITS+2 +: NUM_IDX_BITS]);
  endfunction

  assign arr_rd_data_i          = arr_data[idx_of(arr_rd_addr_o)];
  assign arr_rd_tag_i           = arr_meta[idx_of(arr_rd_addr_o)];
  assign arr_wb_evicted_en_i    = arr_wr_en_o && arr_is_repair_o &&
                                  arr_meta[idx_of(arr_wr_addr_o)].valid &&
                                  arr_meta[idx_of(arr_wr_addr_o)].dirty;
  assign arr_wb_evicted_block_i = arr_data[idx_of(arr_wr_addr_o)];

  always @(posedge clk_i) begin
    if (!arr_init_done) begin
      for (int i = 0; i < 64; i++) begin
        arr_meta[i] <= '0;
        arr_data[i] <= '0;
      end
      arr_init_done <= 1'b1;
    end else if (arr_wr_en_o) begin
      arr_data[idx_of(arr_wr_addr_o)] <= arr_wr_data_o;
      arr_meta[idx_of(arr_wr_addr_o)] <= '{valid: 1'b1,
                                           dirty: arr_is_repair_o ? arr_is_repair_dirty_o : 1'b1,
                                           tag: arr_wr_addr_o[31 -: NUM_TAG_BITS]};
    end
  end

  typedef struct {
    logic            we;
    logic [31:0]     addr;
    cache_data_block wdata;
  } mem_exp_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];

  // Memory agent: accepts requests after ready_delay cycles, answers reads
  // resp_delay cycles later, and checks each accepted request in order.
  int              ready_delay = 0;
  int              resp_delay  = 2;
  int              wait_cnt    = 0;
  int              resp_cnt    = 0;
  int              mem_hs      = 0;
  logic            hs_we       = 1'b0;
  cache_data_block refill_blk  = '0;
  logic [31:0]     snap_addr;
  logic            snap_we;
  cache_data_block snap_wdata;

  initial begin
    mem_exp_t e;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
    forever begin
      @(negedge clk_i);
      mem_resp_valid_i = 1'b0;
      if (mem_req_ready_i) begin
        mem_req_ready_i = 1'b0;
        wait_cnt = 0;
        mem_hs++;
        if (!hs_we) resp_cnt = resp_delay;
      end else if (mem_req_valid_o) begin
        if (wait_cnt == 0) begin
          snap_addr  = mem_req_addr_o;
          snap_we    = mem_req_we_o;
          snap_wdata = mem_req_wdata_o;
        end else begin
          chk("mem_stable_addr", 128'(mem_req_addr_o), 128'(snap_addr));
          chk("mem_stable_we", 128'(mem_req_we_o), 128'(snap_we));
          chk("mem_stable_wdata", mem_req_wdata_o, snap_wdata);
        end
        if (wait_cnt >= ready_delay) begin
          mem_req_ready_i = 1'b1;
          hs_we = mem_req_we_o;
          if (mem_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL mem_unexpected: got we=%0b addr=%h expected no request",
                     mem_req_we_o, mem_req_addr_o);
          end else begin
            e = mem_q.pop_front();
            chk("mem_we", 128'(mem_req_we_o), 128'(e.we));
            chk("mem_addr", 128'(mem_req_addr_o), 128'(e.addr));
            if (e.we) chk("mem_wdata", mem_req_wdata_o, e.wdata);
          end
        end else begin
          wait_cnt++;
        end
      end
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_valid_i = 1'b1;
          mem_resp_data_i  = refill_blk;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    resp_exp_t r;
    forever begin
      @(negedge clk_i);
      if (arr_wr_en_o) wr_cnt++;
      if (resp_valid_o) begin
        if (resp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_unexpected: got rdata=%h expected no response", resp_rdata_o);
        end else begin
          r = resp_q.pop_front();
          chk("resp_rdata", 128'(resp_rdata_o), 128'(r.rdata));
          if (r.lat > 0) chk("resp_latency", 128'(cyc - accept_cyc), 128'(r.lat));
          chk("mem_drained_before_resp", 128'(mem_q.size()), 128'(0));
        end
      end
    end
  end

  task automatic push_mem(input logic we, input logic [31:0] addr, input cache_data_block wd);
    mem_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wd;
    mem_q.push_back(e);
  endtask

  task automatic push_resp(input logic [31:0] rd, input int lat);
    resp_exp_t r;
    r.rdata = rd; r.lat = lat;
    resp_q.push_back(r);
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bit ok = 1'b0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    for (int i = 0; i < 100; i++) begin
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_accept_timeout: got ready=0 expected ready=1");
    end
    accept_cyc = cyc;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_addr_i  = 32'hFFFF_FFFC;
    req_wdata_i = 32'hFFFF_FFFF;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (resp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: got %0d pending expected 0", resp_q.size());
      resp_q.delete();
    end
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, hs0;
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_req_ready", 128'(req_ready_o), 128'(0));
    chk("rst_mem_valid", 128'(mem_req_valid_o), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid_o), 128'(0));
    chk("rst_arr_wr_en", 128'(arr_wr_en_o), 128'(0));
    chk("rst_arr_rd_en", 128'(arr_rd_en_o), 128'(0));
    rst_i = 1'b0;
    #1;
    chk("post_rst_req_ready", 128'(req_ready_o), 128'(1));
    @(negedge clk_i);

    // 1: load miss on empty cache, clean install
    refill_blk = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    push_mem(1'b0, 32'h0000_1040, '0);
    push_resp(32'hA0, 0);
    do_req(1'b0, 32'h0000_1040, 32'h0);
    wait_done();
    chk("s1_meta", 128'(arr_meta[4]), 128'({1'b1, 1'b0, 22'd4}));
    chk("s1_data", arr_data[4], refill_blk);

    // 2: load hit
    push_resp(32'hA1, 2);
    do_req(1'b0, 32'h0000_1044, 32'h0);
    wait_done();

    // 3: store hit marks the line dirty
    push_resp(32'h0, 2);
    do_req(1'b1, 32'h0000_1048, 32'hDEAD_BEEF);
    wait_done();
    chk("s3_data", arr_data[4], {32'hA3, 32'hDEAD_BEEF, 32'hA1, 32'hA0});
    chk("s3_meta", 128'(arr_meta[4]), 128'({1'b1, 1'b1, 22'd4}));

    // 4: conflicting load miss, dirty victim written back after install
    refill_blk = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    push_mem(1'b0, 32'h0000_1440, '0);
    push_mem(1'b1, 32'h0000_1040, {32'hA3, 32'hDEAD_BEEF, 32'hA1, 32'hA0});
    push_resp(32'hB0, 0);
    do_req(1'b0, 32'h0000_1440, 32'h0);
    wait_done();
    chk("s4_meta", 128'(arr_meta[4]), 128'({1'b1, 1'b0, 22'd5}));

    // 5: store miss with slow memory accept
    refill_blk  = '0;
    ready_delay = 5;
    push_mem(1'b0, 32'h0000_2000, '0);
    push_resp(32'h0, 0);
    do_req(1'b1, 32'h0000_2000, 32'h1234_5678);
    wait_done();
    ready_delay = 0;
    chk("s5_data", arr_data[0], {32'h0, 32'h0, 32'h0, 32'h1234_5678});
    chk("s5_meta", 128'(arr_meta[0]), 128'({1'b1, 1'b1, 22'd8}));

    // 6: reset while waiting for refill; late refill pulse must be ignored
    refill_blk = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    resp_delay = 6;
    push_mem(1'b0, 32'h0000_3080, '0);
    hs0 = mem_hs;
    do_req(1'b0, 32'h0000_3080, 32'h0);
    for (int i = 0; i < 50 && mem_hs == hs0; i++) @(negedge clk_i);
    chk("s6_refill_req_seen", 128'(mem_hs - hs0), 128'(1));
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    wr0 = wr_cnt;
    repeat (12) @(negedge clk_i);
    chk("s6_no_array_write", 128'(wr_cnt - wr0), 128'(0));
    chk("s6_idle_ready", 128'(req_ready_o), 128'(1));
    chk("s6_meta_untouched", 128'(arr_meta[8]), 128'(0));
    resp_delay = 2;
    push_resp(32'hB1, 2);
    do_req(1'b0, 32'h0000_1444, 32'h0);
    wait_done();
    chk("end_mem_queue_empty", 128'(mem_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Sequencing controller for the direct-mapped data cache array. It accepts one word-granular load/store request at a time from the processor memory stage and performs the tag lookup. On a hit it serves the request; on a miss it runs refill-from-memory (write-allocate), installs the block, and writes back any dirty victim. It sits between the memory-stage port, the `data_cache` array ports and the main-memory block interface.

## Interface

- No module parameters; geometry comes from `dcache_pkg`:
  - `NUM_TAG_BITS`, `NUM_IDX_BITS`, `BLOCK_OFFSET_BITS`; block = `2**BLOCK_OFFSET_BITS` 32-bit words.
  - `cache_data_block` is the block type.
  - `cache_metadata_block` is `{valid, dirty, tag}`.
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk_i` in 1 — clock.
  - `rst_i` in 1 — synchronous active-high reset.
- Processor side:
  - `req_valid_i` in 1 — request present.
  - `req_we_i` in 1 — 1 = store word, 0 = load word.
  - `req_addr_i` in 32 — word-aligned byte address.
  - `req_wdata_i` in 32 — store data.
  - `req_ready_o` out 1 — request accepted when valid & ready.
  - `resp_valid_o` out 1 — one-cycle completion pulse (loads and stores).
  - `resp_rdata_o` out 32 — load data; 0 for stores.
- Array side:
  - `arr_rd_en_o` out 1 — read enable.
  - `arr_rd_addr_o` out 32 — read address.
  - `arr_rd_data_i` in `cache_data_block` — read data.
  - `arr_rd_tag_i` in `cache_metadata_block` — read metadata.
  - `arr_wr_en_o` out 1 — write enable.
  - `arr_is_repair_o` out 1 — write is a refill install.
  - `arr_is_repair_dirty_o` out 1 — installed block is dirty.
  - `arr_wr_addr_o` out 32 — write address.
  - `arr_wr_data_o` out `cache_data_block` — write data.
  - `arr_wb_evicted_en_i` in 1 — victim is valid and dirty.
  - `arr_wb_evicted_block_i` in `cache_data_block` — victim data.
- Memory side:
  - `mem_req_valid_o` out 1 — request present.
  - `mem_req_we_o` out 1 — 1 = block write, 0 = block read.
  - `mem_req_addr_o` out 32 — block-aligned address.
  - `mem_req_wdata_o` out `cache_data_block` — write data.
  - `mem_req_ready_i` in 1 — request accepted.
  - `mem_resp_valid_i` in 1 — one-cycle pulse carrying refill data.
  - `mem_resp_data_i` in `cache_data_block` — refill data.

## Operation

- Registered request: `addr_q`, `we_q`, `wdata_q`.
- Registered victim: `victim_tag_q`, `victim_q`, `wb_pend_q`.
- States and transitions:
  - IDLE: `req_ready_o`=1; on handshake latch the request → LOOKUP.
  - LOOKUP: `arr_rd_en_o`=1, `arr_rd_addr_o`=`addr_q`. Hit = `valid` && `tag == addr_q[31 -: NUM_TAG_BITS]`.
    - Load hit: capture the word at the offset → RESP.
    - Store hit: `arr_wr_en_o`=1, `is_repair`=0, write data = read block with the offset word replaced by `wdata_q` → RESP.
    - Miss: latch `victim_tag_q` ← read tag → REFILL_REQ.
  - REFILL_REQ: `mem_req_valid_o`=1, `we`=0, `addr` = {`addr_q[31:BLOCK_OFFSET_BITS+2]`, zeros}. Hold stable until `mem_req_ready_i` → REFILL_WAIT.
  - REFILL_WAIT: on `mem_resp_valid_i` latch the block → INSTALL.
  - INSTALL: `arr_wr_en_o`=1, `is_repair`=1.
    - Load: data = refill block, `is_repair_dirty`=0.
    - Store: data = refill block with the offset word replaced, `is_repair_dirty`=1.
    - Same cycle: `wb_pend_q` ← `arr_wb_evicted_en_i`, `victim_q` ← `arr_wb_evicted_block_i`.
    - Next: WB_REQ if `arr_wb_evicted_en_i` else RESP.
  - WB_REQ: `mem_req_valid_o`=1, `we`=1, `addr` = {`victim_tag_q`, `addr_q` index, zeros}, `wdata` = `victim_q`. Hold stable until ready → RESP.
  - RESP: `resp_valid_o`=1 for one cycle with `resp_rdata_o` → IDLE.
- Memory writes are posted: acceptance completes them, no response is expected.
- At most one memory transaction is outstanding.
- `mem_resp_valid_i` is ignored outside REFILL_WAIT.
- Array read and write outputs are 0 in every state that does not drive them.

## Timing

- Reset: state = IDLE and all outputs 0, except `req_ready_o`=1 in the first cycle after reset deasserts.
- Reset mid-operation: abort to IDLE, drop `mem_req_valid_o`, discard latched request and victim. No response is issued for the aborted request.
- Hit latency: accept at cycle T, LOOKUP at T+1, `resp_valid_o` at T+2. Store-hit array write commits at the T+1→T+2 edge.
- Miss latency: T+2 (REFILL_REQ) + memory accept wait + response wait + 1 (INSTALL) + writeback accept wait (if dirty) + 1 (RESP).
- Back-to-back: the next request can be accepted in the cycle after RESP (IDLE). Throughput is one hit per 3 cycles.
- Processor must accept `resp_valid_o`; there is no backpressure.
- `req_wdata_i` and `req_addr_i` are sampled only on the handshake.

## Structure

- `dcache_pkg` holds:
  - the geometry constants and the `cache_data_block` / `cache_metadata_block` types shared with `data_cache`;
  - the state enum `dcache_state_e`;
  - helper functions `blk_addr(tag, idx)` and `word_sel(addr)`.
- One sub-module: `dcache_word_merge`, a combinational block plus offset plus word → merged block. It is used in both the store-hit and store-miss paths.

## Test plan

All scenarios use `NUM_IDX_BITS`=6 and `BLOCK_OFFSET_BITS`=2.

1. Load 0x0000_1040 to an empty cache:
   - Memory read at 0x0000_1040; refill {0xA0,0xA1,0xA2,0xA3}.
   - Install is clean; `resp_rdata_o`=0xA0; no memory write.
2. Load 0x0000_1044 right after scenario 1:
   - Hit; `resp_valid_o` exactly 2 cycles after accept, data 0xA1; no memory activity.
3. Store 0x0000_1048 with data 0xDEAD_BEEF (hit):
   - Array written with word 2 = 0xDEAD_BEEF and marked dirty.
   - Response 2 cycles after accept.
4. Load 0x0000_1440 (same index 4, tag 5), with the set dirty from scenario 3:
   - Memory read at 0x0000_1440 first.
   - After INSTALL, memory write at 0x0000_1040 with {0xA0,0xA1,0xDEAD_BEEF,0xA3}.
   - Then load data is returned.
5. Store miss to 0x0000_2000 with 0x1234_5678, refill all zeros:
   - Installed block is dirty with word 0 = 0x1234_5678.
   - With `mem_req_ready_i` held low 5 cycles, `mem_req_*` stays stable.
6. Assert `rst_i` in REFILL_WAIT, then pulse `mem_resp_valid_i`:
   - Controller stays in IDLE with no array write and no `resp_valid_o`.
   - A new request is accepted normally.
